// File: rtl/lc3b_fetch_unit_if.sv
// rtl/lc3b_fetch_unit_if.sv - instruction memory port bundle for the LC-3b fetch stage
//
// Purpose: carries the hold-until-response instruction read channel.
// Ports:
//   imem_read     read strobe, held until imem_resp
//   imem_address  read address, stable while imem_read is high
//   imem_rdata    instruction word, valid with imem_resp
//   imem_resp     one-cycle read completion
// Modports: master = fetch unit side, slave = memory side.
interface lc3b_fetch_unit_if;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/lc3b_fetch_unit.sv
// rtl/lc3b_fetch_unit.sv - LC-3b instruction fetch stage with redirect squash and IF/ID skid
//
// Purpose: holds the PC, fetches from instruction memory, fills the IF/ID
// register, and squashes wrong-path reads on taken control transfers.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   imem              instruction memory port (master modport)
//   pcmux_sel         00 PC+2, 01 br_target, 10 trap_vec, 11 jmp_target
//   br_taken          redirect request, valid in the cycle asserted
//   br_target, trap_vec, jmp_target  candidate redirect addresses
//   stall             downstream cannot accept; IF/ID holds
//   ifid_valid, ifid_ir, ifid_pc     IF/ID register (ifid_pc = fetch address + 2)
module lc3b_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  lc3b_fetch_unit_if.master        imem,
  input  logic [1:0]               pcmux_sel,
  input  logic                     br_taken,
  input  logic [15:0]              br_target,
  input  logic [15:0]              trap_vec,
  input  logic [15:0]              jmp_target,
  input  logic                     stall,
  output logic                     ifid_valid,
  output logic [15:0]              ifid_ir,
  output logic [15:0]              ifid_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HOLD} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [15:0] pend_pc;
  logic [15:0] skid_ir;
  logic [15:0] skid_pc;
  logic [15:0] redirect_pc;
  logic        redirect;
  logic        read_q;

  // Selecting PC+2 with br_taken is not a transfer, so it never squashes.
  assign redirect = br_taken && (pcmux_sel != 2'b00);
  assign pc_plus2 = pc + 16'd2;

  always_comb begin
    case (pcmux_sel)
      2'b01:   redirect_pc = br_target;
      2'b10:   redirect_pc = trap_vec;
      2'b11:   redirect_pc = jmp_target;
      default: redirect_pc = pc_plus2;
    endcase
    // Instructions are halfword aligned.
    redirect_pc[0] = 1'b0;
  end

  // Memory port comes only from flops: the address is the PC, which does not
  // move while a read is outstanding (DISCARD parks the target in pend_pc).
  assign imem.imem_read    = read_q;
  assign imem.imem_address = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      read_q     <= 1'b0;
      pend_pc    <= 16'h0000;
      skid_ir    <= 16'h0000;
      skid_pc    <= 16'h0000;
      ifid_valid <= 1'b0;
      ifid_ir    <= 16'h0000;
      ifid_pc    <= 16'h0000;
    end else begin
      // IF/ID baseline: flush beats stall; without stall an undelivered
      // cycle becomes a bubble. Deliveries below override this.
      if (redirect || !stall) begin
        ifid_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Any response arriving here belongs to a request abandoned by reset.
          if (redirect) begin
            pc <= redirect_pc;
          end
          state  <= FETCH;
          read_q <= 1'b1;
        end

        FETCH: begin
          if (imem.imem_resp) begin
            if (redirect) begin
              pc <= redirect_pc;
            end else if (!stall) begin
              ifid_valid <= 1'b1;
              ifid_ir    <= imem.imem_rdata;
              ifid_pc    <= pc_plus2;
              pc         <= pc_plus2;
            end else begin
              skid_ir <= imem.imem_rdata;
              skid_pc <= pc_plus2;
              pc      <= pc_plus2;
              state   <= HOLD;
              read_q  <= 1'b0;
            end
          end else if (redirect) begin
            pend_pc <= redirect_pc;
            state   <= DISCARD;
          end
        end

        DISCARD: begin
          // The newest redirect wins, including one coinciding with resp.
          if (redirect) begin
            pend_pc <= redirect_pc;
          end
          if (imem.imem_resp) begin
            pc    <= redirect ? redirect_pc : pend_pc;
            state <= FETCH;
          end
        end

        HOLD: begin
          if (redirect) begin
            pc     <= redirect_pc;
            state  <= FETCH;
            read_q <= 1'b1;
          end else if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_ir    <= skid_ir;
            ifid_pc    <= skid_pc;
            state      <= FETCH;
            read_q     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
